// File: rtl/adc_ltc2308_sequencer_pkg.sv
// Shared types and constants for the LTC2308 scan sequencer.
// Holds the FSM encoding, word widths and the 6-bit ADC config word builder.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 8;
    localparam int CFG_W  = 6;
    localparam int CH_W   = 3;

    // Config word bit positions, MSB is shifted out first
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    localparam logic SD_SINGLE = 1'b1;
    localparam logic UNI_MODE  = 1'b1;
    localparam logic SLP_OFF   = 1'b0;

    // Single-ended, unipolar, awake; channel select bits are scrambled by the ADC mux map
    function automatic logic [CFG_W-1:0] build_cfg(input logic [CH_W-1:0] ch);
        logic [CFG_W-1:0] w;
        w          = '0;
        w[CFG_SD]  = SD_SINGLE;
        w[CFG_OS]  = ch[0];
        w[CFG_S1]  = ch[2];
        w[CFG_S0]  = ch[1];
        w[CFG_UNI] = UNI_MODE;
        w[CFG_SLP] = SLP_OFF;
        return w;
    endfunction

endpackage

// File: rtl/adc_ltc2308_sequencer_next_channel.sv
// Wrap-around channel picker: first set mask bit strictly after cur.
// With cur = 7 it yields the lowest set bit; with one bit set it re-selects cur.
module adc_next_channel
    import adc_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   next,
    output logic              any
);

    // rot[k] is the mask bit k+1 positions after cur
    logic [NUM_CH-1:0] rot;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign rot[gi] = mask[cur + CH_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        next = cur;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                next = cur + CH_W'(k + 1);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/adc_ltc2308_sequencer.sv
// Autonomous round-robin scan controller for the LTC2308 SPI ADC.
// One frame per channel; each frame returns the result of the previous frame's config.
module adc_ltc2308_sequencer #(
    parameter int CONV_CYCLES = 170,
    parameter int SCLK_HALF   = 2,
    parameter int NUM_CH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        busy,
    output logic        sample_valid,
    output logic [2:0]  sample_channel,
    output logic [11:0] sample_data,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout
);

    import adc_seq_pkg::*;

    generate
        if (NUM_CH != adc_seq_pkg::NUM_CH) begin : g_bad_num_ch
            $error("adc_ltc2308_sequencer: NUM_CH must be 8");
        end
        if (CONV_CYCLES < 1 || SCLK_HALF < 1) begin : g_bad_timing
            $error("adc_ltc2308_sequencer: CONV_CYCLES and SCLK_HALF must be >= 1");
        end
    endgenerate

    localparam int CNT_MAX = (CONV_CYCLES > 2 * SCLK_HALF) ? CONV_CYCLES : 2 * SCLK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [3:0]          bit_reg, bit_next;
    logic [CH_W-1:0]     cur_ch_reg, cur_ch_next;
    logic [CH_W-1:0]     prev_ch_reg, prev_ch_next;
    logic                dummy_reg, dummy_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [CFG_W-1:0]    cfg_sr_reg, cfg_sr_next;

    logic                busy_reg, busy_next;
    logic                valid_reg, valid_next;
    logic [CH_W-1:0]     ch_out_reg, ch_out_next;
    logic [DATA_W-1:0]   data_out_reg, data_out_next;
    logic                cs_reg, cs_next;
    logic                sclk_reg, sclk_next;
    logic                din_reg, din_next;

    logic [CH_W-1:0]     pick_cur;
    logic [CH_W-1:0]     next_ch;
    logic                mask_any;
    logic [CFG_W-1:0]    cfg_word;

    // In IDLE start the search from channel 7 so the lowest set bit wins
    assign pick_cur = (state_reg == IDLE) ? CH_W'(NUM_CH - 1) : cur_ch_reg;
    assign cfg_word = build_cfg(cur_ch_reg);

    adc_next_channel u_next_channel (
        .mask (ch_mask),
        .cur  (pick_cur),
        .next (next_ch),
        .any  (mask_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            cur_ch_reg   <= '0;
            prev_ch_reg  <= '0;
            dummy_reg    <= 1'b1;
            shift_reg    <= '0;
            cfg_sr_reg   <= '0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            ch_out_reg   <= '0;
            data_out_reg <= '0;
            cs_reg       <= 1'b0;
            sclk_reg     <= 1'b0;
            din_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            cur_ch_reg   <= cur_ch_next;
            prev_ch_reg  <= prev_ch_next;
            dummy_reg    <= dummy_next;
            shift_reg    <= shift_next;
            cfg_sr_reg   <= cfg_sr_next;
            busy_reg     <= busy_next;
            valid_reg    <= valid_next;
            ch_out_reg   <= ch_out_next;
            data_out_reg <= data_out_next;
            cs_reg       <= cs_next;
            sclk_reg     <= sclk_next;
            din_reg      <= din_next;
        end
    end

    // Pin and sample outputs are computed from the next state so they line up with state_reg
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        cur_ch_next   = cur_ch_reg;
        prev_ch_next  = prev_ch_reg;
        dummy_next    = dummy_reg;
        shift_next    = shift_reg;
        cfg_sr_next   = cfg_sr_reg;
        valid_next    = 1'b0;
        ch_out_next   = ch_out_reg;
        data_out_next = data_out_reg;
        din_next      = din_reg;

        case (state_reg)
            IDLE: begin
                if (enable && mask_any) begin
                    state_next  = CONV;
                    cnt_next    = '0;
                    cur_ch_next = next_ch;
                    dummy_next  = 1'b1;
                end
            end
            CONV: begin
                if (cnt_reg == CNT_W'(CONV_CYCLES - 1)) begin
                    state_next  = SHIFT;
                    cnt_next    = '0;
                    bit_next    = '0;
                    din_next    = cfg_word[CFG_W-1];
                    cfg_sr_next = {cfg_word[CFG_W-2:0], 1'b0};
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SHIFT: begin
                // Rising adc_sclk edge: ADC data bit is stable here
                if (cnt_reg == CNT_W'(SCLK_HALF - 1)) begin
                    shift_next = {shift_reg[DATA_W-2:0], adc_dout};
                end
                if (cnt_reg == CNT_W'(2 * SCLK_HALF - 1)) begin
                    cnt_next = '0;
                    if (bit_reg == 4'(DATA_W - 1)) begin
                        state_next    = DONE;
                        valid_next    = ~dummy_reg;
                        ch_out_next   = dummy_reg ? ch_out_reg : prev_ch_reg;
                        data_out_next = dummy_reg ? data_out_reg : shift_next;
                    end else begin
                        bit_next    = bit_reg + 4'd1;
                        din_next    = cfg_sr_reg[CFG_W-1];
                        cfg_sr_next = {cfg_sr_reg[CFG_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                prev_ch_next = cur_ch_reg;
                dummy_next   = 1'b0;
                if (mask_any) begin
                    cur_ch_next = next_ch;
                end
                cnt_next = '0;
                if (enable && mask_any) begin
                    state_next = CONV;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next != SHIFT) begin
            din_next = 1'b0;
        end
        busy_next = (state_next != IDLE);
        cs_next   = (state_next == CONV);
        sclk_next = (state_next == SHIFT) && (cnt_next >= CNT_W'(SCLK_HALF));
    end

    assign busy           = busy_reg;
    assign sample_valid   = valid_reg;
    assign sample_channel = ch_out_reg;
    assign sample_data    = data_out_reg;
    assign adc_cs_n       = cs_reg;
    assign adc_sclk       = sclk_reg;
    assign adc_din        = din_reg;

endmodule

// File: tb/tb_adc_ltc2308_sequencer.sv
// Bench for adc_ltc2308_sequencer: LTC2308 pin model, pin-timing monitor and a sample scoreboard.
// The ADC model answers each frame with 12'hA00 | (channel configured in the previous frame).
module tb_adc_ltc2308_sequencer;

    localparam int CONV_CYCLES = 170;
    localparam int SCLK_HALF   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        busy;
    logic        sample_valid;
    logic [2:0]  sample_channel;
    logic [11:0] sample_data;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_dout;

    adc_ltc2308_sequencer #(
        .CONV_CYCLES (CONV_CYCLES),
        .SCLK_HALF   (SCLK_HALF),
        .NUM_CH      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .ch_mask        (ch_mask),
        .busy           (busy),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .adc_din        (adc_din),
        .adc_dout       (adc_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
    } sample_t;

    sample_t exp_q[$];
    sample_t mon_e;

    function automatic void push_sample(input logic [2:0] ch);
        sample_t s;
        s.ch   = ch;
        s.data = 12'hA00 | {9'd0, ch};
        exp_q.push_back(s);
    endfunction

    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_channel", int'(sample_channel), int'(mon_e.ch));
                check("sample_data", int'(sample_data), int'(mon_e.data));
                $display("sample ch=%0d data=0x%03h", sample_channel, sample_data);
            end
        end
    end

    // ---------------- LTC2308 pin model ----------------
    logic [11:0] adc_sr = '0;
    logic [5:0]  cfg_cap = '0;
    logic [5:0]  cfg_log[$];
    logic [2:0]  adc_ch = '0;
    logic        m_prev_sclk = 1'b0;
    int          cfg_bits = 0;
    int          din_tail_err = 0;

    assign adc_dout = adc_sr[11];

    always @(negedge clk) begin
        m_prev_sclk <= adc_sclk;
        if (adc_cs_n) begin
            adc_sr   <= 12'hA00 | {9'd0, adc_ch};
            cfg_bits <= 0;
        end else begin
            if (m_prev_sclk && !adc_sclk) begin
                adc_sr <= {adc_sr[10:0], 1'b0};
            end
            if (!m_prev_sclk && adc_sclk) begin
                if (cfg_bits < 6) begin
                    cfg_cap <= {cfg_cap[4:0], adc_din};
                end else if (adc_din) begin
                    din_tail_err <= din_tail_err + 1;
                end
                if (cfg_bits == 5) begin
                    cfg_log.push_back({cfg_cap[4:0], adc_din});
                    adc_ch <= {cfg_cap[2], cfg_cap[1], cfg_cap[3]};
                end
                cfg_bits <= cfg_bits + 1;
            end
        end
    end

    // ---------------- pin timing monitor ----------------
    int   cyc = 0, cs_run = 0, last_cs_run = 0, last_rise = 0, last_period = 0;
    int   n_rise = 0, pulses = 0, last_pulses = 0, hi_run = 0, bad_width = 0, sclk_in_conv = 0;
    logic mon_prev_cs = 1'b0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        mon_prev_cs <= adc_cs_n;
        if (adc_cs_n) begin
            cs_run <= cs_run + 1;
        end else begin
            if (cs_run != 0) last_cs_run <= cs_run;
            cs_run <= 0;
        end
        if (adc_cs_n && !mon_prev_cs) begin
            last_period <= cyc - last_rise;
            last_rise   <= cyc;
            n_rise      <= n_rise + 1;
            last_pulses <= pulses;
            pulses      <= 0;
        end else if (!adc_sclk && hi_run != 0) begin
            pulses <= pulses + 1;
        end
        if (adc_sclk) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0 && hi_run != SCLK_HALF) bad_width <= bad_width + 1;
            hi_run <= 0;
        end
        if (adc_sclk && adc_cs_n) sclk_in_conv <= sclk_in_conv + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset   = 1'b1;
        enable  = 1'b0;
        ch_mask = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        cfg_log.delete();
    endtask

    task automatic wait_drained(input string name, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic wait_rise(input string name, input int target, input int budget);
        int i = 0;
        while (n_rise < target && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(n_rise >= target), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] mask;
        logic [2:0] ch_a;
        logic [2:0] ch_b;
        logic [5:0] cfg_a;
        logic [5:0] cfg_b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int base;
        int i;

        vecs[0] = '{8'h05, 3'd0, 3'd2, 6'b100010, 6'b100110};
        vecs[1] = '{8'h80, 3'd7, 3'd7, 6'b111110, 6'b111110};
        vecs[2] = '{8'h12, 3'd1, 3'd4, 6'b110010, 6'b101010};
        vecs[3] = '{8'hA0, 3'd5, 3'd7, 6'b111010, 6'b111110};

        // Reset state
        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_adc_cs_n", int'(adc_cs_n), 0);
        check("rst_adc_sclk", int'(adc_sclk), 0);
        check("rst_adc_din", int'(adc_din), 0);
        check("rst_sample_channel", int'(sample_channel), 0);
        check("rst_sample_data", int'(sample_data), 0);

        // Frame timing on channel 0
        push_sample(3'd0);
        push_sample(3'd0);
        base    = n_rise;
        ch_mask = 8'h01;
        enable  = 1'b1;
        wait_rise("timing_rise_timeout", base + 3, 1000);
        enable = 1'b0;
        check("cs_high_cycles", last_cs_run, CONV_CYCLES);
        check("sclk_pulses", last_pulses, 12);
        check("frame_period", last_period, CONV_CYCLES + 24 * SCLK_HALF + 1);
        check("sclk_high_width_errors", bad_width, 0);
        check("sclk_during_conv", sclk_in_conv, 0);
        check("cfg_ch0", int'(cfg_log[0]), int'(6'b100010));
        check("din_tail_nonzero", din_tail_err, 0);
        wait_drained("timing_drain_timeout", 1000);
        wait_idle("timing_idle_timeout", 1000);

        // Table-driven scans: three samples each, then stop
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push_sample(vecs[v].ch_a);
            push_sample(vecs[v].ch_b);
            push_sample(vecs[v].ch_a);
            ch_mask = vecs[v].mask;
            enable  = 1'b1;
            wait_drained("scan_drain_timeout", 2000);
            enable = 1'b0;
            wait_idle("scan_idle_timeout", 500);
            check("scan_cfg_count", cfg_log.size(), 4);
            check("scan_cfg_a", int'(cfg_log[0]), int'(vecs[v].cfg_a));
            check("scan_cfg_b", int'(cfg_log[1]), int'(vecs[v].cfg_b));
            $display("scan mask=0x%02h cfg0=%06b cfg1=%06b", vecs[v].mask, cfg_log[0], cfg_log[1]);
        end

        // Enable dropped 10 cycles into CONV of frame 3
        do_reset();
        push_sample(3'd0);
        push_sample(3'd2);
        base    = n_rise;
        ch_mask = 8'h05;
        enable  = 1'b1;
        wait_rise("drop_rise_timeout", base + 3, 1000);
        for (int k = 0; k < 9; k++) tick();
        enable = 1'b0;
        i = 0;
        while (!(sample_valid && exp_q.size() == 0) && i < 1000) begin
            tick();
            i++;
        end
        check("drop_last_sample_seen", exp_q.size(), 0);
        check("busy_in_done", int'(busy), 1);
        tick();
        check("busy_after_done", int'(busy), 0);
        base = n_rise;
        for (int k = 0; k < 300; k++) tick();
        check("drop_no_new_frame", n_rise - base, 0);
        check("drop_cs_n_low", int'(adc_cs_n), 0);

        // Reset mid-SHIFT (bit 5); sample outputs still hold ch2 / 0xA02 here
        base    = n_rise;
        ch_mask = 8'h01;
        enable  = 1'b1;
        wait_rise("rstmid_rise_timeout", base + 1, 100);
        i = 0;
        while (adc_cs_n && i < 400) begin
            tick();
            i++;
        end
        for (int k = 0; k < 5 * 2 * SCLK_HALF + SCLK_HALF; k++) tick();
        check("sclk_high_before_reset", int'(adc_sclk), 1);
        reset = 1'b1;
        tick();
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_sample_valid", int'(sample_valid), 0);
        check("rstmid_adc_cs_n", int'(adc_cs_n), 0);
        check("rstmid_adc_sclk", int'(adc_sclk), 0);
        check("rstmid_adc_din", int'(adc_din), 0);
        check("rstmid_sample_channel", int'(sample_channel), 0);
        check("rstmid_sample_data", int'(sample_data), 0);
        push_sample(3'd0);
        base  = n_rise;
        reset = 1'b0;
        wait_drained("restart_drain_timeout", 1000);
        check("restart_first_frame_discarded", n_rise - base, 2);
        enable = 1'b0;
        wait_idle("restart_idle_timeout", 500);

        // Empty mask keeps the sequencer idle; then ch4 starts
        do_reset();
        base    = n_rise;
        ch_mask = 8'h00;
        enable  = 1'b1;
        for (int k = 0; k < 50; k++) tick();
        check("empty_mask_busy", int'(busy), 0);
        check("empty_mask_no_frame", n_rise - base, 0);
        check("empty_mask_cs_n", int'(adc_cs_n), 0);
        push_sample(3'd4);
        ch_mask = 8'h10;
        wait_drained("ch4_drain_timeout", 1000);
        check("cfg_ch4", int'(cfg_log[0]), int'(6'b101010));
        enable = 1'b0;
        wait_idle("ch4_idle_timeout", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
